mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage load/store unit that sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Converts latched EX/MEM control and data into a request/acknowledge data-memory transaction: byte enables, store-data lane replication, load extraction with sign/zero extension.
- Stalls the pipeline while a transaction is outstanding and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUSY without dmem_ack_i before the access is aborted with bus_err_o (1..65535).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
mem_alu_result_i  input  32  effective address / ALU result from EX/MEM
mem_rs2_data_i  input  32  store data from EX/MEM
mem_rd_addr_i  input  5  destination register
mem_funct3_i  input  3  access size/sign (RV32I load/store funct3)
mem_mem_read_i  input  1  load
mem_mem_write_i  input  1  store
mem_reg_write_i  input  1  WB write enable
mem_mem_to_reg_i  input  2  WB mux select, passed through
dmem_req_o  output  1  memory request, held until ack
dmem_we_o  output  1  1 = write
dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_o  output  32  lane-replicated store data
dmem_be_o  output  4  byte enables
dmem_ack_i  input  1  single-cycle acknowledge; dmem_rdata_i valid with it
dmem_rdata_i  input  32  read word
stall_o  output  1  hold PC/IF/ID/ID-EX/EX-MEM this cycle
wb_alu_result_o  output  32  pass-through of mem_alu_result_i
wb_load_data_o  output  32  extended load data (registered)
wb_rd_addr_o  output  5  pass-through
wb_reg_write_o  output  1  qualified WB write enable
wb_mem_to_reg_o  output  2  pass-through
misaligned_o  output  1  misaligned access this cycle
bus_err_o  output  1  timeout abort, one cycle

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, timeout counter=0, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, dmem_be_o=0, wb_load_data_o=0, bus_err_o=0. stall_o, misaligned_o and wb_reg_write_o are forced to 0 while rst=1. Reset mid-transaction drops dmem_req_o after that edge; any late ack in IDLE is ignored.
- Access = mem_mem_read_i | mem_mem_write_i. If both are set, the access is a load and the write is ignored.
- Size: funct3[1:0] 00=byte, 01=half, 10/11=word; funct3[2]=1 selects zero extension (LBU/LHU). Off = addr[1:0].
- Misaligned: half with off[0]=1, or word with off!=0. In this case misaligned_o=1 combinationally, no request is issued, stall_o=0, wb_reg_write_o=0.
- Byte enables: byte -> 4'b0001<<off; half -> 4'b0011<<off; word -> 4'b1111.
- Store data: byte {4{rs2[7:0]}}; half {2{rs2[15:0]}}; word rs2.
- FSM IDLE:
  - Aligned access present: latch addr/we/wdata/be into the dmem_* regs, clear the counter, go to BUSY. stall_o=1 this cycle.
  - Otherwise: pass-through, stall_o=0, wb_reg_write_o=mem_reg_write_i.
- FSM BUSY: dmem_req_o=1, all dmem_* outputs stable, stall_o=1, wb_reg_write_o=0.
  - On dmem_ack_i: latch the extended load data (stores latch 0), go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: set bus_err_o, load data=0, go to DONE.
  - Else: counter+1.
- FSM DONE: dmem_req_o=0, stall_o=0, wb_reg_write_o = mem_reg_write_i & ~bus_err_o. EX/MEM advances at the end of this cycle; the next state is IDLE unconditionally, so the same instruction is never relaunched. bus_err_o clears on leaving DONE.
- Load extraction: byte = rdata[8*off+7 : 8*off]; half = rdata[16*off[1]+15 : 16*off[1]]; sign- or zero-extended to 32 bits.
- Latency: minimum access = 3 cycles (IDLE launch, BUSY with ack, DONE). Non-memory instructions take 0 added cycles.

Test Plan:
1. LW addr 0x100, ack in 3rd BUSY cycle, rdata 0xDEADBEEF -> req held 3 cycles, addr 0x100, be 1111, stall 4 cycles, DONE: wb_load_data 0xDEADBEEF, wb_reg_write=1.
2. LB addr 0x203, rdata 0x80FF_0000 -> wb_load_data 0xFFFFFF80; same with LBU -> 0x00000080.
3. SH addr 0x302, rs2 0x1234ABCD, immediate ack -> we=1, be 1100, wdata 0xABCDABCD, addr 0x300, wb_reg_write=0.
4. LW addr 0x101 -> misaligned_o=1, dmem_req_o stays 0, stall_o=0, wb_reg_write_o=0.
5. LW with no ack, TIMEOUT_CYCLES=4 -> 4 BUSY cycles, then DONE with bus_err_o=1 and wb_load_data 0; IDLE next cycle.
6. rst asserted during the 2nd BUSY cycle, then ack one cycle later -> req low after the reset edge, state IDLE, ack ignored, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Signal suffixes are written from the point of view of the MEM stage.
interface mem_access_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_ack_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage load/store unit: turns EX/MEM control into a req/ack data-memory
// transaction, stalls the pipeline while it is outstanding, extends load data,
// and flags misaligned accesses and bus timeouts.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_alu_result_i,
    input  logic [31:0]         mem_rs2_data_i,
    input  logic [4:0]          mem_rd_addr_i,
    input  logic [2:0]          mem_funct3_i,
    input  logic                mem_mem_read_i,
    input  logic                mem_mem_write_i,
    input  logic                mem_reg_write_i,
    input  logic [1:0]          mem_mem_to_reg_i,
    mem_access_stage_if.master  dmem,
    output logic                stall_o,
    output logic [31:0]         wb_alu_result_o,
    output logic [31:0]         wb_load_data_o,
    output logic [4:0]          wb_rd_addr_o,
    output logic                wb_reg_write_o,
    output logic [1:0]          wb_mem_to_reg_o,
    output logic                misaligned_o,
    output logic                bus_err_o
);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        req_q, we_q, bus_err_q;
    logic [31:0] addr_q, wdata_q, load_q;
    logic [3:0]  be_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        is_load_q;

    logic        access, misalign, launch;
    logic [1:0]  off;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, load_ext;
    logic [7:0]  rd_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign access = mem_mem_read_i | mem_mem_write_i;
    assign off    = mem_alu_result_i[1:0];

    // Half needs even offset, word needs offset zero; bytes are always aligned.
    assign misalign = ((mem_funct3_i[1:0] == 2'b01) & off[0]) |
                      (mem_funct3_i[1] & (off != 2'b00));
    assign launch   = access & ~misalign;

    // Byte enables and lane-replicated store data for the current instruction.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = mem_rs2_data_i;
        case (mem_funct3_i[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << off;
                wdata_calc = {4{mem_rs2_data_i[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << off;
                wdata_calc = {2{mem_rs2_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Split the returned word into byte lanes for offset-based selection.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi] = dmem.dmem_rdata_i[8*gi +: 8];
    end

    assign byte_sel = rd_lane[off_q];
    assign half_sel = off_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];

    // Sign/zero extension uses the size and offset captured at launch.
    always_comb begin
        load_ext = dmem.dmem_rdata_i;
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    // Transaction FSM with registered bus outputs, load data and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            load_q    <= '0;
            bus_err_q <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            is_load_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        addr_q    <= {mem_alu_result_i[31:2], 2'b00};
                        we_q      <= mem_mem_write_i & ~mem_mem_read_i;
                        wdata_q   <= wdata_calc;
                        be_q      <= be_calc;
                        funct3_q  <= mem_funct3_i;
                        off_q     <= off;
                        is_load_q <= mem_mem_read_i;
                        cnt_q     <= '0;
                        req_q     <= 1'b1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack_i) begin
                        load_q  <= is_load_q ? load_ext : 32'd0;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        bus_err_q <= 1'b1;
                        load_q    <= '0;
                        req_q     <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    bus_err_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pipeline control: stall while launching/outstanding, qualify WB write.
    always_comb begin
        stall_o        = 1'b0;
        wb_reg_write_o = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    stall_o        = launch;
                    wb_reg_write_o = mem_reg_write_i & ~access;
                end
                BUSY:    stall_o = 1'b1;
                DONE:    wb_reg_write_o = mem_reg_write_i & ~bus_err_q;
                default: ;
            endcase
        end
    end

    assign misaligned_o      = ~rst & access & misalign;
    assign bus_err_o         = bus_err_q;
    assign wb_load_data_o    = load_q;
    assign wb_alu_result_o   = mem_alu_result_i;
    assign wb_rd_addr_o      = mem_rd_addr_i;
    assign wb_mem_to_reg_o   = mem_mem_to_reg_i;

    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign dmem.dmem_be_o    = be_q;
endmodule
